// File: rtl/cache_ctrl.sv
// Write-through, write-allocate cache controller sequencing CPU requests between a
// single-cycle cache lookup and a handshaked main memory, with hit/miss statistics.
module cache_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_ready,
   output logic             busy,
   output logic [31:0]      cache_addr,
   output logic [31:0]      cache_wdata,
   output logic             cache_write,
   input  logic [31:0]      cache_rdata,
   input  logic             cache_hit,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ack,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOOKUP = 3'd1;
   localparam logic [2:0] MEM_RD = 3'd2;
   localparam logic [2:0] FILL   = 3'd3;
   localparam logic [2:0] CWR    = 3'd4;
   localparam logic [2:0] MEM_WR = 3'd5;
   localparam logic [2:0] RESP   = 3'd6;

   logic [2:0]  state_reg;
   logic [2:0]  state_next;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] mdata_reg;
   logic [31:0] rdata_reg;
   logic        in_lookup;
   logic [1:0]  cnt_inc;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (cpu_req) state_next = LOOKUP;
         LOOKUP: begin
            if (we_reg)         state_next = CWR;
            else if (cache_hit) state_next = RESP;
            else                state_next = MEM_RD;
         end
         MEM_RD:  if (mem_ack) state_next = FILL;
         FILL:    state_next = RESP;
         CWR:     state_next = MEM_WR;
         MEM_WR:  if (mem_ack) state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         we_reg    <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         mdata_reg <= '0;
         rdata_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && cpu_req) begin
            we_reg    <= cpu_we;
            addr_reg  <= cpu_addr;
            wdata_reg <= cpu_wdata;
         end
         if (state_reg == MEM_RD && mem_ack)
            mdata_reg <= mem_rdata;
         // Response data only moves on reads, so a write leaves the last read visible.
         if (state_reg == LOOKUP && !we_reg && cache_hit)
            rdata_reg <= cache_rdata;
         if (state_reg == FILL)
            rdata_reg <= mdata_reg;
      end
   end

   assign in_lookup  = (state_reg == LOOKUP);
   assign cnt_inc[0] = in_lookup & cache_hit;
   assign cnt_inc[1] = in_lookup & ~cache_hit;

   // Index 0 counts hits, index 1 counts misses; both saturate and clear wins.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               cnt_reg <= '0;
            else if (stats_clr)
               cnt_reg <= '0;
            else if (cnt_inc[gi] && cnt_reg != {CNT_W{1'b1}})
               cnt_reg <= cnt_reg + CNT_W'(1);
         end
      end
   endgenerate

   assign hit_count   = g_cnt[0].cnt_reg;
   assign miss_count  = g_cnt[1].cnt_reg;

   assign busy        = (state_reg != IDLE);
   assign cpu_ready   = (state_reg == RESP);
   assign cpu_rdata   = rdata_reg;
   assign cache_addr  = addr_reg;
   assign cache_write = (state_reg == FILL) || (state_reg == CWR);
   assign cache_wdata = (state_reg == FILL) ? mdata_reg : wdata_reg;
   assign mem_req     = (state_reg == MEM_RD) || (state_reg == MEM_WR);
   assign mem_we      = (state_reg == MEM_WR);
   assign mem_addr    = addr_reg;
   assign mem_wdata   = wdata_reg;

endmodule
